// File: rtl/wallace_seq_multiplier_ctrl.sv
// ============================================================================
// wallace_seq_multiplier_ctrl : multi-cycle unsigned WIDTHxWIDTH multiplier on one shared 8x8 Wallace tree.
// Optional: MUL_ZERO_BYPASS_EN (zero operand skips CALC).   Rev 1.0
// ============================================================================
`default_nettype none

module wallace_tree_multiplier_top (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] product_o
);

  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  logic [15:0] w_pp [8];
  logic [15:0] w_l1 [6];
  logic [15:0] w_l2 [4];
  logic [15:0] w_l3 [3];
  logic [15:0] w_l4 [2];

  // Wallace reduction 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_pp[k] = b_i[k] ? (16'(a_i) << k) : 16'd0;
    end
    {w_l1[0], w_l1[1]} = csa(w_pp[0], w_pp[1], w_pp[2]);
    {w_l1[2], w_l1[3]} = csa(w_pp[3], w_pp[4], w_pp[5]);
    w_l1[4] = w_pp[6];
    w_l1[5] = w_pp[7];
    {w_l2[0], w_l2[1]} = csa(w_l1[0], w_l1[1], w_l1[2]);
    {w_l2[2], w_l2[3]} = csa(w_l1[3], w_l1[4], w_l1[5]);
    {w_l3[0], w_l3[1]} = csa(w_l2[0], w_l2[1], w_l2[2]);
    w_l3[2] = w_l2[3];
    {w_l4[0], w_l4[1]} = csa(w_l3[0], w_l3[1], w_l3[2]);
    product_o = w_l4[0] + w_l4[1];
  end

endmodule

module wallace_seq_multiplier_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WIDTH-1:0]     multiplier_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);

  localparam int NCHUNK = WIDTH / 8;
  localparam int IDX_W  = $clog2(NCHUNK * NCHUNK + 1);
  localparam logic [IDX_W-1:0] C_NCHUNK = IDX_W'(NCHUNK);
  localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(NCHUNK * NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_i;
  logic [IDX_W-1:0]   w_j;
  logic [7:0]         w_a_chunk;
  logic [7:0]         w_b_chunk;
  logic [15:0]        w_pp;
  logic [2*WIDTH-1:0] w_pp_shifted;

  assign w_i = r_idx / C_NCHUNK;
  assign w_j = r_idx % C_NCHUNK;

  // Tree inputs are forced to zero outside CALC so the shared tree stays quiet
  always_comb begin
    w_a_chunk = 8'd0;
    w_b_chunk = 8'd0;
    if (r_state == S_CALC) begin
      w_a_chunk = 8'(r_a >> {w_i, 3'b000});
      w_b_chunk = 8'(r_b >> {w_j, 3'b000});
    end
  end

  wallace_tree_multiplier_top u_tree (
    .a_i       (w_a_chunk),
    .b_i       (w_b_chunk),
    .product_o (w_pp)
  );

  assign w_pp_shifted = (2*WIDTH)'(w_pp) << {(w_i + w_j), 3'b000};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
`ifdef MUL_ZERO_BYPASS_EN
          if ((multiplier_i == '0) || (multiplicand_i == '0)) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_CALC;
          end
`else
          w_next_state = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (r_idx == C_LAST) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready_i) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      S_IDLE:  req_ready_o = 1'b1;
      S_CALC:  busy_o = 1'b1;
      S_DONE: begin
        resp_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      if (r_state == S_IDLE && req_valid_i) begin
        r_a   <= multiplier_i;
        r_b   <= multiplicand_i;
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= r_acc + w_pp_shifted;
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign product_o = r_acc;

endmodule

`default_nettype wire
